// File: rtl/pipe_pkg.sv
// pipe_pkg: scoreboard entry type, bubble constant and bypass-availability helper
package pipe_pkg;
  localparam int SB_AW = 8;
  typedef struct packed {
    logic             v;
    logic             wen;
    logic             ld;
    logic [SB_AW-1:0] dst;
  } sb_entry_t;
  localparam sb_entry_t SB_BUBBLE = '0;
  function automatic logic avail(input int k, input logic ld, input int ld_lat);
    return ld ? (k >= 2 + ld_lat) : (k >= 2);
  endfunction
endpackage

// File: rtl/sb_match.sv
// sb_match: youngest in-flight producer of one source register, searched over stages 1..DEPTH-1
module sb_match
  import pipe_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic [SB_AW-1:0] src_i,
  input  logic             use_i,
  input  sb_entry_t        ent_i [1:DEPTH],
  output logic             hit_o,
  output logic [SW-1:0]    j_o,
  output logic             ld_o
);
  // Scan oldest to youngest so the lowest stage overwrites; the WB stage is excluded.
  always_comb begin
    hit_o = 1'b0;
    j_o   = '0;
    ld_o  = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--)
      if (use_i && src_i != '0 && ent_i[k].v && ent_i[k].wen && ent_i[k].dst == src_i) begin
        hit_o = 1'b1;
        j_o   = SW'(k);
        ld_o  = ent_i[k].ld;
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard driving load-use stall, registered EX bypass selects
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter  int DEPTH  = 3,
  parameter  int REG_AW = 5,
  parameter  int LD_LAT = 1,
  localparam int SW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wen,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_ld,
  input  logic              flush,
  input  logic              mem_wait,
  output logic              stall,
  output logic [SW-1:0]     fwd_sel_a,
  output logic [SW-1:0]     fwd_sel_b,
  output logic [31:0]       stall_cnt
);
  sb_entry_t     e_q [1:DEPTH];
  sb_entry_t     e_d [1:DEPTH];
  logic [SW-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, j_a, j_b;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          hit_a, hit_b, ld_a, ld_b, issue;

  sb_match #(.DEPTH(DEPTH)) u_rs (
    .src_i(SB_AW'(id_rs)), .use_i(id_use_rs), .ent_i(e_q), .hit_o(hit_a), .j_o(j_a), .ld_o(ld_a)
  );
  sb_match #(.DEPTH(DEPTH)) u_rt (
    .src_i(SB_AW'(id_rt)), .use_i(id_use_rt), .ent_i(e_q), .hit_o(hit_b), .j_o(j_b), .ld_o(ld_b)
  );

  // A producer at stage j reaches stage j+1 by the time the consumer is in EX.
  assign stall = id_valid && !flush &&
                 ((hit_a && !avail(int'(j_a) + 1, ld_a, LD_LAT)) ||
                  (hit_b && !avail(int'(j_b) + 1, ld_b, LD_LAT)));
  assign issue     = id_valid && !flush && !stall;
  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    e_d         = e_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_wait) begin
      for (int k = DEPTH; k >= 2; k--) e_d[k] = e_q[k-1];
      e_d[1]      = issue ? sb_entry_t'{v: 1'b1, wen: id_wen, ld: id_ld, dst: SB_AW'(id_dst)} : SB_BUBBLE;
      fwd_a_d     = (issue && hit_a) ? j_a + SW'(1) : '0;
      fwd_b_d     = (issue && hit_b) ? j_b + SW'(1) : '0;
      stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) e_q[k] <= SB_BUBBLE;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
